// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 7-segment display.
// Latches a packed BCD word and scans it one digit per slot, blanking anodes at each slot start.
module display_scan_driver #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BLANK_LZ     = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  output logic [3:0]              num,
  output logic [N_DIGITS-1:0]     an,
  output logic [2:0]              digit_idx
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [4*N_DIGITS-1:0] value_q;
  logic [4*N_DIGITS-1:0] value_next;
  logic [CNT_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [2:0]            idx_next;
  logic [3:0]            num_next;
  logic [N_DIGITS-1:0]   an_next;
  logic                  wrap;

  // Display code: raw nibble, or 4'hF when it and every higher digit are zero.
  function automatic logic [3:0] digit_code(input logic [4*N_DIGITS-1:0] v,
                                            input logic [2:0] i);
    logic       upper_zero;
    logic [3:0] nib;
    upper_zero = 1'b1;
    nib        = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (k >= 32'(i) && v[4*k +: 4] != 4'h0) upper_zero = 1'b0;
      if (k == 32'(i)) nib = v[4*k +: 4];
    end
    if (BLANK_LZ != 0 && i != 3'd0 && upper_zero) return 4'hF;
    return nib;
  endfunction

  assign value_next = load ? bcd_in : value_q;
  assign wrap       = (div_cnt == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    cnt_next = '0;
    idx_next = '0;
    num_next = num;
    an_next  = '1;
    if (!enable) begin
      num_next = digit_code(value_next, 3'd0);
    end else begin
      if (wrap) begin
        cnt_next = '0;
        idx_next = (digit_idx == 3'(N_DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
        num_next = digit_code(value_next, idx_next);
      end else begin
        cnt_next = div_cnt + CNT_W'(1);
        idx_next = digit_idx;
      end
      // an is computed from the post-edge count so it lines up with div_cnt.
      if (32'(cnt_next) >= BLANK_CYCLES) begin
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
          an_next[k] = (k != 32'(idx_next));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q   <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      num       <= '0;
      an        <= '1;
    end else begin
      value_q   <= value_next;
      div_cnt   <= cnt_next;
      digit_idx <= idx_next;
      num       <= num_next;
      an        <= an_next;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: a cycle-count model of the scan, checked every cycle,
// with two instances (leading-zero blanking on and off) sharing stimulus.
module tb_display_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  num1, num0;
  logic [3:0]  an1, an0;
  logic [2:0]  idx1, idx0;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .bcd_in(bcd_in),
    .num(num1), .an(an1), .digit_idx(idx1));

  display_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .bcd_in(bcd_in),
    .num(num0), .an(an0), .digit_idx(idx0));

  always #5 clk = ~clk;

  // Model: m_t counts enabled cycles since scanning (re)started; slot = m_t/8.
  logic [15:0] m_val;
  int          m_t;
  logic [3:0]  m_num1, m_num0;

  function automatic logic [3:0] code(input logic [15:0] v, input int i, input bit lz);
    logic [15:0] hi;
    hi = v >> (4 * i);
    if (lz && i != 0 && hi == 16'h0) return 4'hF;
    return hi[3:0];
  endfunction

  function automatic int m_idx();
    return (m_t / 8) % 4;
  endfunction

  function automatic logic [3:0] m_an();
    if (m_t % 8 < 2) return 4'hF;
    return ~(4'b0001 << m_idx());
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_val = '0; m_t = 0; m_num1 = '0; m_num0 = '0;
    end else begin
      if (load) m_val = bcd_in;
      if (!enable) begin
        m_t = 0;
        m_num1 = code(m_val, 0, 1'b1);
        m_num0 = code(m_val, 0, 1'b0);
      end else begin
        m_t = m_t + 1;
        if (m_t % 8 == 0) begin
          m_num1 = code(m_val, m_idx(), 1'b1);
          m_num0 = code(m_val, m_idx(), 1'b0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("num_lz",   32'(num1), 32'(m_num1));
    chk("num_nolz", 32'(num0), 32'(m_num0));
    chk("an_lz",    32'(an1),  32'(m_an()));
    chk("an_nolz",  32'(an0),  32'(m_an()));
    chk("idx_lz",   32'(idx1), 32'(m_idx()));
    chk("idx_nolz", 32'(idx0), 32'(m_idx()));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_t(input int target);
    int b;
    b = 0;
    while (m_t != target && b < 200) begin
      cyc();
      b++;
    end
    if (m_t != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_t: reached %0d, wanted %0d", m_t, target);
    end
  endtask

  // Load v with scanning stopped, restart, and pin each slot's num/an to literals.
  task automatic scan_check(input logic [15:0] v, input logic [15:0] e1, input logic [15:0] e0);
    logic [3:0] e_an;
    load = 1'b1; bcd_in = v; enable = 1'b0;
    cyc();
    load = 1'b0; enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_t(8 * s + 1);
      chk("lit_blank_an", 32'(an1), 32'hF);
      wait_t(8 * s + 2);
      e_an = ~(4'b0001 << s);
      chk("lit_drive_an", 32'(an1), 32'(e_an));
      chk("lit_num_lz",   32'(num1), 32'(e1[4*s +: 4]));
      chk("lit_num_nolz", 32'(num0), 32'(e0[4*s +: 4]));
      chk("lit_idx",      32'(idx1), 32'(s));
    end
    wait_t(32);
    chk("lit_wrap_idx", 32'(idx1), 32'd0);
    chk("lit_wrap_an",  32'(an1),  32'hF);
  endtask

  initial begin
    logic [15:0] v;
    int          k;
    repeat (3) cyc();
    chk("lit_reset_num", 32'(num1), 32'h0);
    chk("lit_reset_an",  32'(an1),  32'hF);
    chk("lit_reset_idx", 32'(idx1), 32'h0);
    reset_n = 1'b1;
    cyc();

    scan_check(16'h0045, 16'hFF45, 16'h0045);
    scan_check(16'h0000, 16'hFFF0, 16'h0000);
    scan_check(16'h00A0, 16'hFFA0, 16'h00A0);
    scan_check(16'h1234, 16'h1234, 16'h1234);

    // Mid-slot load: captured at div_cnt=4 of slot 1 (digit 1).
    wait_t(43);
    load = 1'b1; bcd_in = 16'h9999;
    cyc();
    load = 1'b0;
    wait_t(46);
    chk("lit_midload_keep", 32'(num1), 32'h3);
    wait_t(50);
    chk("lit_midload_next", 32'(num1), 32'h9);
    // Load on the wrap edge itself.
    wait_t(55);
    load = 1'b1; bcd_in = 16'h5678;
    cyc();
    load = 1'b0;
    chk("lit_wrapload_num", 32'(num1), 32'h5);
    chk("lit_wrapload_idx", 32'(idx1), 32'h3);

    // Enable drop in slot 2 DRIVE.
    wait_t(82);
    enable = 1'b0;
    cyc();
    chk("lit_dis_an",  32'(an1),  32'hF);
    chk("lit_dis_idx", 32'(idx1), 32'h0);
    chk("lit_dis_num", 32'(num1), 32'h8);
    enable = 1'b1;
    cyc();
    chk("lit_reen_blank", 32'(an1), 32'hF);
    cyc();
    chk("lit_reen_an",  32'(an1),  32'hE);
    chk("lit_reen_num", 32'(num1), 32'h8);

    // Asynchronous reset mid-scan.
    wait_t(13);
    reset_n = 1'b0;
    #1;
    chk("lit_areset_num", 32'(num1), 32'h0);
    chk("lit_areset_an",  32'(an1),  32'hF);
    chk("lit_areset_idx", 32'(idx1), 32'h0);
    repeat (3) cyc();
    chk("lit_hold_an",  32'(an1),  32'hF);
    chk("lit_hold_num", 32'(num1), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      v = 16'($urandom);
      k = $urandom_range(0, 4);
      if (k > 0) v = v & (16'hFFFF >> (4 * k));
      bcd_in  = v;
      load    = ($urandom_range(0, 7) == 0);
      enable  = ($urandom_range(0, 19) != 0);
      reset_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    reset_n = 1'b1;
    load = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
